pe_issue_writeback: RTL
=======================

// Module: pe_issue_writeback
// PURPOSE
//  Instruction sequencer for one SCGRA PE: fetches statically scheduled instructions,
//  reads three operands from PE data memory and issues them with an opcode to the
//  fixed-latency ALU. It then writes ALU_Out back to the data memory at the delayed
//  destination address. No hazard checks: the compiler schedule guarantees no RAW/WAW conflicts.
// PARAMETERS
//  DWIDTH       32  datapath width
//  IADDR_WIDTH  8   instruction memory address width
//  DADDR_WIDTH  8   data memory address width
//  ALU_LATENCY  3   cycles from ALU_In*/Opcode valid to ALU_Out valid (>=1)
// PORTS
//  Clk            in   1              clock, rising edge
//  Resetn         in   1              asynchronous reset, active-low
//  Start          in   1              run request, sampled in IDLE only
//  Inst_Count     in   IADDR_WIDTH+1  number of instructions to execute (0..2^IADDR_WIDTH)
//  Busy           out  1              1 from the Start-accept edge until the Done cycle inclusive
//  Done           out  1              one-cycle completion pulse
//  Inst_Rd_En     out  1              instruction memory read enable
//  Inst_Addr      out  IADDR_WIDTH    instruction address (PC)
//  Inst_Data      in   4+4*DADDR_WIDTH  {dst,src2,src1,src0,opcode[3:0]}, valid 1 cycle after Inst_Rd_En
//  Rd_Addr0..2    out  DADDR_WIDTH    data memory read addresses (src0..src2)
//  Rd_Data0..2    in   DWIDTH         read data, valid 1 cycle after Rd_Addr*
//  ALU_In0..2     out  DWIDTH         ALU operands
//  Opcode         out  4              ALU opcode (0000 = NOP)
//  ALU_Out        in   DWIDTH         ALU result
//  Wr_En          out  1              data memory write enable
//  Wr_Addr        out  DADDR_WIDTH    write address
//  Wr_Data        out  DWIDTH         write data
//  Op_Count       out  IADDR_WIDTH+1  writebacks done in current run; cleared on Start accept
// BEHAVIOUR
//  Reset: FSM=IDLE, PC=0, all outputs 0 (Opcode=0000), valid/dst delay lines cleared.
//  FSM: IDLE -> FETCH on Start & Inst_Count!=0; IDLE -> DONE on Start & Inst_Count==0.
//   FETCH: Inst_Rd_En=1, Inst_Addr=PC, PC+1 per cycle; after issuing PC=Inst_Count-1 -> DRAIN.
//   DRAIN: count 2+ALU_LATENCY cycles (pipeline empty, last Wr_En seen) -> DONE.
//   DONE: Done=1, Busy=1 for one cycle -> IDLE. PC cleared on Start accept.
//  Start while not IDLE is ignored. Inst_Count is sampled at Start accept.
//  Pipeline, T = cycle Inst_Addr=k is driven:
//   T+1: Rd_Addr0..2 = src fields of Inst_Data, driven combinationally; opcode/dst/valid registered.
//   T+2: ALU_In0..2 = Rd_Data0..2, driven combinationally; Opcode = registered opcode.
//    Opcode=0000 when no valid issue.
//   T+2+ALU_LATENCY: Wr_En=1, Wr_Addr=dst, Wr_Data=ALU_Out when the issued opcode != 0000.
//  Opcode/dst/valid delay line is a shift register ALU_LATENCY deep; full throughput is
//   1 instr/cycle and back-to-back writebacks are allowed.
//  NOP (0000): still occupies its issue slot, but gives no Wr_En and no Op_Count increment.
//  Op_Count increments on each Wr_En and is held after Done until next Start accept.
//  Inst_Count = 2^IADDR_WIDTH: PC wraps to 0 after the last issue; no extra fetch.
//  Reset mid-run: immediate abort; no Wr_En after Resetn falls; Done not pulsed.
//  Wr_En in the same cycle as Done is impossible: DRAIN covers the full latency.
// TESTING
//  1 Reset: Resetn=0 with random inputs -> Busy=Done=Wr_En=Inst_Rd_En=0, Opcode=0, Op_Count=0.
//  2 Single op: Inst_Count=1, inst0={dst=0x10,src=2,1,0,op=0011}, mem[0..2]={5,7,3}, model ALU L=3
//    -> Inst_Addr=0 one cycle after Start; Wr_En 5 cycles later: Wr_Addr=0x10, Wr_Data=15.
//    Done pulses 6 cycles after Inst_Rd_En; Op_Count=1.
//  3 Back-to-back: 4 instrs, op[2]=0000 -> 3 Wr_En on T+5,T+6,T+8 at correct dst; Op_Count=3.
//  4 Empty run: Start with Inst_Count=0 -> Done one cycle after Start, Inst_Rd_En never 1, Op_Count=0.
//  5 Abort: Resetn=0 two cycles into an 8-instr run -> no Wr_En thereafter; after release, IDLE.
//  6 Start ignored: Start pulsed during FETCH and DRAIN -> single Done; instruction sequence unchanged.

Source files
------------

// File: rtl/pe_issue_writeback.sv
// Instruction sequencer for one SCGRA processing element.
// Fetches statically scheduled instructions and reads three operands from data memory.
// Issues each instruction to a fixed-latency ALU, then writes the result back to the
// destination address that was carried alongside the instruction.
// There is no hazard logic because the compiler schedule already rules out RAW/WAW conflicts.
module pe_issue_writeback #(
  parameter int DWIDTH      = 32,
  parameter int IADDR_WIDTH = 8,
  parameter int DADDR_WIDTH = 8,
  parameter int ALU_LATENCY = 3
) (
  input  logic                       Clk,
  input  logic                       Resetn,
  input  logic                       Start,
  input  logic [IADDR_WIDTH:0]       Inst_Count,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Inst_Rd_En,
  output logic [IADDR_WIDTH-1:0]     Inst_Addr,
  input  logic [4+4*DADDR_WIDTH-1:0] Inst_Data,
  output logic [DADDR_WIDTH-1:0]     Rd_Addr0,
  output logic [DADDR_WIDTH-1:0]     Rd_Addr1,
  output logic [DADDR_WIDTH-1:0]     Rd_Addr2,
  input  logic [DWIDTH-1:0]          Rd_Data0,
  input  logic [DWIDTH-1:0]          Rd_Data1,
  input  logic [DWIDTH-1:0]          Rd_Data2,
  output logic [DWIDTH-1:0]          ALU_In0,
  output logic [DWIDTH-1:0]          ALU_In1,
  output logic [DWIDTH-1:0]          ALU_In2,
  output logic [3:0]                 Opcode,
  input  logic [DWIDTH-1:0]          ALU_Out,
  output logic                       Wr_En,
  output logic [DADDR_WIDTH-1:0]     Wr_Addr,
  output logic [DWIDTH-1:0]          Wr_Data,
  output logic [IADDR_WIDTH:0]       Op_Count
);

  // Drain must cover operand read + issue + full ALU latency so the last writeback lands before Done.
  localparam int DRAIN_CYCLES = 2 + ALU_LATENCY;
  localparam int DCW          = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [IADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [IADDR_WIDTH:0]     count_q, count_d;
  logic [DCW-1:0]           drain_q, drain_d;
  logic [IADDR_WIDTH:0]     op_count_q, op_count_d;
  logic [IADDR_WIDTH:0]     last_idx;

  // Operand-read stage: Inst_Data is valid the cycle after a fetch.
  logic                     fetch_valid_q;
  // Issue stage: what the ALU sees this cycle.
  logic                     iss_valid_q;
  logic [3:0]               iss_op_q;
  logic [DADDR_WIDTH-1:0]   iss_dst_q;
  // Delay line matching the ALU latency; the tail lines up with ALU_Out.
  logic                     dl_valid_q [ALU_LATENCY];
  logic [3:0]               dl_op_q    [ALU_LATENCY];
  logic [DADDR_WIDTH-1:0]   dl_dst_q   [ALU_LATENCY];

  logic [3:0]               inst_op;
  logic [DADDR_WIDTH-1:0]   inst_src0, inst_src1, inst_src2, inst_dst;

  assign inst_op   = Inst_Data[3:0];
  assign inst_src0 = Inst_Data[4 +: DADDR_WIDTH];
  assign inst_src1 = Inst_Data[4 + DADDR_WIDTH +: DADDR_WIDTH];
  assign inst_src2 = Inst_Data[4 + 2*DADDR_WIDTH +: DADDR_WIDTH];
  assign inst_dst  = Inst_Data[4 + 3*DADDR_WIDTH +: DADDR_WIDTH];

  assign last_idx = count_q - {{IADDR_WIDTH{1'b0}}, 1'b1};

  // Control state, PC, run length, drain counter and writeback counter.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      count_q    <= '0;
      drain_q    <= '0;
      op_count_q <= '0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      drain_q    <= drain_d;
      op_count_q <= op_count_d;
    end
  end

  // Next-state logic and FSM-driven outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    drain_d    = drain_q;
    op_count_d = op_count_q + {{IADDR_WIDTH{1'b0}}, Wr_En};
    Inst_Rd_En = 1'b0;
    Busy       = (state_q != S_IDLE);
    Done       = (state_q == S_DONE);
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          count_d    = Inst_Count;
          pc_d       = '0;
          op_count_d = '0;
          state_d    = (Inst_Count != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        Inst_Rd_En = 1'b1;
        pc_d       = pc_q + {{(IADDR_WIDTH-1){1'b0}}, 1'b1};
        if ({1'b0, pc_q} == last_idx) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + DCW'(1);
        if (drain_q == DRAIN_LAST) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign Inst_Addr = Inst_Rd_En ? pc_q : '0;

  // Operand fetch and issue registers: opcode/dst move one stage per cycle.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      fetch_valid_q <= 1'b0;
      iss_valid_q   <= 1'b0;
      iss_op_q      <= '0;
      iss_dst_q     <= '0;
    end else begin
      fetch_valid_q <= Inst_Rd_En;
      iss_valid_q   <= fetch_valid_q;
      iss_op_q      <= fetch_valid_q ? inst_op  : 4'b0000;
      iss_dst_q     <= fetch_valid_q ? inst_dst : '0;
    end
  end

  // Shift the issued opcode/dst down the latency-matched delay line.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      // NOTE: the delay line is reset because stale valid bits would cause spurious writes after an abort.
      for (int i = 0; i < ALU_LATENCY; i++) begin
        dl_valid_q[i] <= 1'b0;
        dl_op_q[i]    <= '0;
        dl_dst_q[i]   <= '0;
      end
    end else begin
      dl_valid_q[0] <= iss_valid_q;
      dl_op_q[0]    <= iss_op_q;
      dl_dst_q[0]   <= iss_dst_q;
      for (int i = 1; i < ALU_LATENCY; i++) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_op_q[i]    <= dl_op_q[i-1];
        dl_dst_q[i]   <= dl_dst_q[i-1];
      end
    end
  end

  assign Rd_Addr0 = fetch_valid_q ? inst_src0 : '0;
  assign Rd_Addr1 = fetch_valid_q ? inst_src1 : '0;
  assign Rd_Addr2 = fetch_valid_q ? inst_src2 : '0;

  assign ALU_In0  = iss_valid_q ? Rd_Data0 : '0;
  assign ALU_In1  = iss_valid_q ? Rd_Data1 : '0;
  assign ALU_In2  = iss_valid_q ? Rd_Data2 : '0;
  assign Opcode   = iss_op_q;

  // A NOP still travels down the pipe but never writes back.
  assign Wr_En    = dl_valid_q[ALU_LATENCY-1] && (dl_op_q[ALU_LATENCY-1] != 4'b0000);
  assign Wr_Addr  = Wr_En ? dl_dst_q[ALU_LATENCY-1] : '0;
  assign Wr_Data  = Wr_En ? ALU_Out : '0;
  assign Op_Count = op_count_q;

endmodule
